sipo_deserializer: RTL
======================

// Module: sipo_deserializer
// PURPOSE
//  Serial-in/parallel-out stage consuming the registered 1-bit stream from the D flip-flop stage.
//  Packs WIDTH consecutive valid bits into a word and presents it downstream on a valid/ready handshake.
//  Holds one word in an output register plus one in the shift register; flags overrun when input is lost.
// PARAMETERS
//  WIDTH      8   bits per output word, >= 2
//  MSB_FIRST  1   1: first received bit lands in dout[WIDTH-1]; 0: first bit lands in dout[0]
// PORTS
//  clk         in   1      rising-edge clock, single clock domain
//  rst_n       in   1      asynchronous active-low reset
//  clr         in   1      synchronous clear: drop partial word, output word and overrun flag
//  din         in   1      serial data bit (Q of upstream flip-flop)
//  din_valid   in   1      din carries a bit this cycle
//  din_ready   out  1      stage accepts a bit this cycle
//  dout        out  WIDTH  assembled word, stable while dout_valid=1
//  dout_valid  out  1      dout holds an unconsumed word
//  dout_ready  in   1      downstream accepts dout this cycle
//  bit_cnt     out  clog2(WIDTH+1)  bits held in shift register, 0..WIDTH
//  overrun     out  1      sticky: a bit was offered while din_ready=0
// BEHAVIOUR
//  Reset (rst_n=0, async): state=COLLECT, sr=0, bit_cnt=0, dout=0, dout_valid=0, overrun=0, din_ready=1.
//  Bit accept: din_valid & din_ready at a rising edge -> shift din into sr, bit_cnt+1.
//   MSB_FIRST=1: sr <= {sr[WIDTH-2:0], din}; MSB_FIRST=0: sr <= {din, sr[WIDTH-1:1]}.
//  Output accept: dout_valid & dout_ready at an edge -> dout_valid=0 unless reloaded in the same edge.
//  FSM states: COLLECT, STALL.
//   COLLECT: din_ready=1. When accepted bit is the WIDTH-th (bit_cnt==WIDTH-1):
//    - out slot free (dout_valid=0) or freed this edge (dout_ready=1): dout<=completed word,
//      dout_valid<=1, bit_cnt<=0, stay COLLECT. Latency: last bit edge -> dout_valid high after that edge.
//    - else: word remains in sr, bit_cnt<=WIDTH, go STALL.
//   STALL: din_ready=0. On dout_ready=1: dout<=sr, dout_valid stays 1, bit_cnt<=0, go COLLECT
//    (din_ready=1 again the cycle after).
//  Back-to-back: with dout_ready held 1, one word per WIDTH valid bits, no bubbles.
//  Overrun: din_valid=1 while din_ready=0 -> bit dropped, overrun<=1, held until clr or reset.
//  clr: highest priority synchronous event; same end values as reset; a bit offered with clr is dropped
//   and does not set overrun. clr has no effect on din_ready combinationally.
//  din_valid=0: nothing shifts; partial word held indefinitely (no timeout).
//  Reset mid-word or mid-stall: all state discarded immediately, no partial output emitted.
//  dout changes only on an edge where dout_valid transitions 0->1 or a handshake reloads it.
//  din and dout_ready sampled only at rising clk; no combinational path din_valid -> din_ready.
// STRUCTURE
//  Shared package deser_pkg: state enum {COLLECT, STALL}, CNT_W function clog2(WIDTH+1).
//  Single module, no sub-modules; sr/bit_cnt/FSM and output register in one always block each.
// TESTING
//  1 WIDTH=8,MSB_FIRST=1, dout_ready=1, bits 1,0,1,0,0,1,0,1 -> dout=8'hA5, dout_valid 1 cycle after 8th bit.
//  2 Same bits, MSB_FIRST=0 -> dout=8'hA5 reversed = 8'hA5 bit-reversed = 8'hA5; then bits 1,1,0,0,0,0,0,0 -> 8'h03.
//  3 dout_ready=0, send 16 bits (8'h0F then 8'hF0) -> first word held, STALL, din_ready=0; raise dout_ready ->
//    8'h0F consumed, next cycle dout=8'hF0, din_ready=1.
//  4 In STALL, offer din_valid=1 for 3 cycles -> overrun=1, bit_cnt stays 8; clr -> overrun=0, dout_valid=0.
//  5 Send 5 bits, pulse rst_n low mid-cycle -> outputs zero immediately, next 8 bits form a clean word.
//  6 Continuous 32 bits with dout_ready=1 -> 4 words, dout_valid pulses exactly every 8 cycles, overrun=0.

Source files
------------

// File: rtl/deser_pkg.sv
// Shared types and sizing helpers for the serial-in/parallel-out deserializer.
// Holds the FSM state encoding and the bit-counter width calculation.
package deser_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        STALL   = 1'b1
    } state_e;

    // Counter must hold 0..width inclusive, so size it for width+1 values.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out stage: packs WIDTH accepted bits into a word and hands it
// downstream over valid/ready. One word buffered in dout, one more parked in the shift register.
module sipo_deserializer
    import deser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      din,
    input  logic                      din_valid,
    output logic                      din_ready,
    output logic [WIDTH-1:0]          dout,
    output logic                      dout_valid,
    input  logic                      dout_ready,
    output logic [cnt_w(WIDTH)-1:0]   bit_cnt,
    output logic                      overrun
);

    localparam int CNT_W = cnt_w(WIDTH);

    state_e             state_r;
    state_e             state_nxt_s;
    logic [WIDTH-1:0]   sr_r;
    logic [CNT_W-1:0]   bit_cnt_r;
    logic [WIDTH-1:0]   dout_r;
    logic               dout_valid_r;
    logic               overrun_r;

    logic               din_ready_s;
    logic               bit_acc_s;
    logic               last_bit_s;
    logic               slot_free_s;
    logic               stall_rel_s;
    logic               word_load_s;
    logic               out_take_s;
    logic [WIDTH-1:0]   sr_shift_s;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
        if (MSB_FIRST != 0) begin
            return {cur[WIDTH-2:0], b};
        end else begin
            return {b, cur[WIDTH-1:1]};
        end
    endfunction

    // Handshake and word-completion qualifiers shared by all registers.
    always_comb begin
        bit_acc_s   = din_valid & din_ready_s;
        last_bit_s  = bit_acc_s & (bit_cnt_r == CNT_W'(WIDTH - 1));
        slot_free_s = ~dout_valid_r | dout_ready;
        stall_rel_s = (state_r == STALL) & dout_ready;
        out_take_s  = dout_valid_r & dout_ready;
        word_load_s = (last_bit_s & slot_free_s) | stall_rel_s;
        sr_shift_s  = shift_in(sr_r, din);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= COLLECT;
        end else if (clr) begin
            state_r <= COLLECT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: park a completed word in sr when the output slot is still occupied.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            COLLECT: begin
                if (last_bit_s && !slot_free_s) begin
                    state_nxt_s = STALL;
                end else begin
                    state_nxt_s = COLLECT;
                end
            end
            STALL: begin
                if (dout_ready) begin
                    state_nxt_s = COLLECT;
                end else begin
                    state_nxt_s = STALL;
                end
            end
            default: state_nxt_s = COLLECT;
        endcase
    end

    // FSM outputs: decoded from the state flop only, so no din_valid -> din_ready path.
    always_comb begin
        din_ready_s = 1'b1;
        case (state_r)
            COLLECT: din_ready_s = 1'b1;
            STALL:   din_ready_s = 1'b0;
            default: din_ready_s = 1'b1;
        endcase
    end

    // Shift register and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_r      <= {WIDTH{1'b0}};
            bit_cnt_r <= CNT_W'(0);
        end else if (clr) begin
            sr_r      <= {WIDTH{1'b0}};
            bit_cnt_r <= CNT_W'(0);
        end else if (stall_rel_s) begin
            sr_r      <= sr_r;
            bit_cnt_r <= CNT_W'(0);
        end else if (bit_acc_s) begin
            sr_r <= sr_shift_s;
            if (last_bit_s && slot_free_s) begin
                bit_cnt_r <= CNT_W'(0);
            end else begin
                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
        end else begin
            sr_r      <= sr_r;
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Output word register: loads on completion or stall release, otherwise drains on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_r       <= {WIDTH{1'b0}};
            dout_valid_r <= 1'b0;
        end else if (clr) begin
            dout_r       <= {WIDTH{1'b0}};
            dout_valid_r <= 1'b0;
        end else if (word_load_s) begin
            dout_r       <= stall_rel_s ? sr_r : sr_shift_s;
            dout_valid_r <= 1'b1;
        end else if (out_take_s) begin
            dout_r       <= dout_r;
            dout_valid_r <= 1'b0;
        end else begin
            dout_r       <= dout_r;
            dout_valid_r <= dout_valid_r;
        end
    end

    // Sticky overrun: a bit offered while stalled is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_r <= 1'b0;
        end else if (clr) begin
            overrun_r <= 1'b0;
        end else if (din_valid && !din_ready_s) begin
            overrun_r <= 1'b1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign din_ready  = din_ready_s;
    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign bit_cnt    = bit_cnt_r;
    assign overrun    = overrun_r;

endmodule
